// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving a word-only SRAM, with read-modify-write for byte and halfword stores
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rd
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic [2:0]        state, state_nx;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              accept;
    logic              err;
    logic [4:0]        bsh;
    logic [4:0]        hsh;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;
    logic [31:0]       bmask;
    logic [31:0]       hmask;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign mem_addr  = {{(32 - ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
    assign mem_re    = (state == RD) && rst_n;
    assign mem_we    = (state == WR) && rst_n;
    assign mem_wd    = (state == WR) ? merge_q : 32'd0;

    // Reject illegal size, misalignment and addresses beyond the SRAM before touching memory
    always_comb begin
        err = (req_size == SZ_X)
           || (req_size == SZ_H && req_addr[0])
           || (req_size == SZ_W && req_addr[1:0] != 2'b00)
           || (req_addr[31:ADDR_W+2] != '0);
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores, from the captured read word
    always_comb begin
        bsh       = {addr_q[1:0], 3'b000};
        hsh       = {addr_q[1], 4'b0000};
        lane_b    = 8'(mem_rd >> bsh);
        lane_h    = 16'(mem_rd >> hsh);
        bmask     = 32'h0000_00FF << bsh;
        hmask     = 32'h0000_FFFF << hsh;
        load_val  = (size_q == SZ_B) ? {{24{sgn_q & lane_b[7]}}, lane_b} :
                    (size_q == SZ_H) ? {{16{sgn_q & lane_h[15]}}, lane_h} : mem_rd;
        merge_val = (size_q == SZ_B) ? ((mem_rd & ~bmask) | ({24'd0, wdata_q[7:0]} << bsh)) :
                                       ((mem_rd & ~hmask) | ({16'd0, wdata_q} << hsh));
    end

    // Next-state sequencing: error -> RESP, word store -> WR, everything else reads first
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = err ? RESP : (req_we && req_size == SZ_W) ? WR : RD;
            RD:   state_nx = CAP;
            CAP:  state_nx = we_q ? WR : RESP;
            WR:   state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and request/response registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            merge_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q    <= req_addr[ADDR_W+1:0];
                size_q    <= req_size;
                sgn_q     <= req_signed;
                we_q      <= req_we;
                wdata_q   <= req_wdata[15:0];
                merge_q   <= req_wdata;
                rsp_rdata <= '0;
                rsp_err   <= err;
            end
            if (state == CAP && !we_q) rsp_rdata <= load_val;
            if (state == CAP && we_q) merge_q <= merge_val;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural SRAM
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_re;
    wire  [31:0] mem_rd;

    logic [31:0] sram [32];
    logic [31:0] rd_q = '0;
    logic        rd_v = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          both = 0;

    int          lat, nre, nwe;
    logic [31:0] rd, wds, ma;
    logic        er;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd)
    );

    // Single-port word SRAM with registered read data, high-Z when not returning a read
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr[4:0]] <= mem_wd;
        rd_v <= mem_re;
        if (mem_re) rd_q <= sram[mem_addr[4:0]];
    end
    assign mem_rd = rd_v ? rd_q : 32'hzzzz_zzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, follow it to its response, hold the response 'hold' cycles, then take it
    task automatic req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, output int l, output logic [31:0] r,
                       output logic e, output int c_re, output int c_we, output logic [31:0] w_seen,
                       output logic [31:0] a_seen);
        c_re = 0; c_we = 0; w_seen = '0; a_seen = '0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        for (l = 1; l <= 20; l++) begin
            if (mem_re) c_re++;
            if (mem_we) begin c_we++; w_seen = mem_wd; end
            if (mem_re && mem_we) both++;
            if (l == 1) a_seen = mem_addr;
            if (rsp_valid) break;
            tick();
        end
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        r = rsp_rdata;
        e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, r);
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_en", {30'd0, mem_we, mem_re}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        // preload through word stores
        req(1, 2'b10, 0, 32'h0C, 32'h0000_0005, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("wst_lat", lat, 2);
        chk("wst_en", {nre[15:0], nwe[15:0]}, 32'h0000_0001);
        chk("wst_rdata", rd, 32'd0);
        req(1, 2'b10, 0, 32'h14, 32'h0000_0008, 0, lat, rd, er, nre, nwe, wds, ma);
        req(1, 2'b10, 0, 32'h08, 32'h80FF_7F01, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("wst_wd", wds, 32'h80FF_7F01);

        // word load
        req(0, 2'b10, 0, 32'h0C, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("wld_lat", lat, 3);
        chk("wld_data", rd, 32'h0000_0005);
        chk("wld_en", {nre[15:0], nwe[15:0]}, 32'h0001_0000);
        chk("wld_addr", ma, 32'd3);
        chk("wld_err", {31'd0, er}, 32'd0);

        // byte store RMW then reload
        req(1, 2'b00, 0, 32'h15, 32'h1234_56AB, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("bst_lat", lat, 4);
        chk("bst_en", {nre[15:0], nwe[15:0]}, 32'h0001_0001);
        chk("bst_wd", wds, 32'h0000_AB08);
        chk("bst_rdata", rd, 32'd0);
        req(0, 2'b10, 0, 32'h14, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("bst_reload", rd, 32'h0000_AB08);

        // extension
        req(0, 2'b00, 1, 32'h0B, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("sb_0b", rd, 32'hFFFF_FF80);
        req(0, 2'b01, 0, 32'h0A, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("uh_0a", rd, 32'h0000_80FF);
        req(0, 2'b01, 1, 32'h08, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("sh_08", rd, 32'h0000_7F01);
        req(0, 2'b00, 0, 32'h09, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("ub_09", rd, 32'h0000_007F);
        req(0, 2'b00, 1, 32'h0A, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("sb_0a", rd, 32'hFFFF_FFFF);
        req(0, 2'b01, 1, 32'h0A, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("sh_0a", rd, 32'hFFFF_80FF);

        // halfword store RMW on the upper half
        req(1, 2'b01, 0, 32'h0A, 32'hFFFF_1234, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("hst_lat", lat, 4);
        chk("hst_wd", wds, 32'h1234_7F01);
        req(0, 2'b10, 0, 32'h08, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("hst_reload", rd, 32'h1234_7F01);

        // errors
        req(0, 2'b01, 0, 32'h03, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("eh_lat", lat, 1);
        chk("eh_err", {31'd0, er}, 32'd1);
        chk("eh_en", {nre[15:0], nwe[15:0]}, 32'd0);
        chk("eh_rdata", rd, 32'd0);
        req(0, 2'b10, 0, 32'h80, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("ew_range", {31'd0, er}, 32'd1);
        req(1, 2'b11, 0, 32'h00, 32'hFFFF_FFFF, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("e_size", {31'd0, er}, 32'd1);
        chk("e_size_en", {nre[15:0], nwe[15:0]}, 32'd0);
        req(1, 2'b10, 0, 32'h06, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("e_walign", {31'd0, er}, 32'd1);
        req(0, 2'b10, 0, 32'h08, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("e_nowrite", rd, 32'h1234_7F01);
        chk("e_clears", {31'd0, er}, 32'd0);

        // backpressure
        req(0, 2'b10, 0, 32'h0C, 32'h0, 5, lat, rd, er, nre, nwe, wds, ma);
        chk("bp_data", rd, 32'h0000_0005);

        // reset in CAP of a byte store to word 5 (restored to 8 first)
        req(1, 2'b10, 0, 32'h14, 32'h0000_0008, 0, lat, rd, er, nre, nwe, wds, ma);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h15; req_wdata = 32'h0000_00CD;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_en", {30'd0, mem_we, mem_re}, 32'd0);
        chk("mr_addr", mem_addr, 32'd0);
        chk("mr_wd", mem_wd, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_novalid", {31'd0, rsp_valid}, 32'd0);
        end
        req(0, 2'b10, 0, 32'h14, 32'h0, 0, lat, rd, er, nre, nwe, wds, ma);
        chk("mr_word5", rd, 32'h0000_0008);

        chk("we_re_excl", both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit sitting directly upstream of the single-port word SRAM in the MIPS datapath. It accepts one memory request at a time from the MEM pipeline stage over a valid/ready handshake and drives the SRAM's address, write-data and read/write enable pins. It captures the SRAM's registered read data and returns extracted, extended load data, or a store acknowledge, over a second valid/ready handshake. Byte and halfword stores are built as read-modify-write sequences because the SRAM is word-only.

## Interface
- ADDR_W, 5, SRAM word-index width (32 words)
- clk  in  1  rising-edge clock shared with the SRAM
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (low byte/half used for sub-word)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected, no memory access made
- mem_addr  out  32  word index, zero-extended to 32 bits
- mem_wd  out  32  SRAM write data
- mem_we  out  1  SRAM write enable
- mem_re  out  1  SRAM read enable
- mem_rd  in  32  SRAM read data; registered and valid the cycle after mem_re; high-Z otherwise

## Operation
- States: IDLE, RD, CAP, WR, RESP.
- req_ready = (state == IDLE). A handshake in IDLE latches addr, size, signed, we and wdata.
- Error check at accept. rsp_err is set for any of:
  - req_size = 11
  - halfword with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:ADDR_W+2] != 0
- An error goes IDLE -> RESP with rsp_err = 1 and rsp_rdata = 0. mem_we and mem_re are never asserted.
- Word store: IDLE -> WR -> RESP.
- Load or sub-word store: IDLE -> RD -> CAP.
  - Load: CAP -> RESP.
  - Sub-word store: CAP -> WR -> RESP.
- State outputs:
  - RD: mem_re = 1, mem_we = 0.
  - WR: mem_we = 1, mem_re = 0, mem_wd = merge register.
  - Every other state: both enables 0.
- mem_addr = latched addr[ADDR_W+1:2], zero-extended. It is held from accept until the return to IDLE.
- CAP samples mem_rd. mem_rd is sampled in CAP only and must not be used in any other state (high-Z).
  - Load: extract the lane (little-endian), then extend per req_signed.
    - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
    - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Sub-word store: the merge register takes mem_rd with only the addressed byte/half replaced by req_wdata[7:0] / [15:0].
- Word store: merge register = req_wdata.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready = 1, then returns to IDLE. Stores respond with rsp_rdata = 0, rsp_err = 0.
- No request bypass: req_ready rises the cycle after the response handshake.

## Timing
- Cycle 0 is the accept edge. rsp_valid first rises:
  - error: cycle 1
  - word store: cycle 2
  - load: cycle 3
  - sub-word store: cycle 4
- Read path: mem_re is high in cycle 1. SRAM data arrives after that edge and is sampled at the end of cycle 2 (CAP).
- The SRAM write commits at the rising edge ending the WR cycle.
- Reset values (asynchronous, immediate on rst_n low):
  - state = IDLE, req_ready = 1 once rst_n is high
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - mem_addr = 0, mem_wd = 0, mem_we = 0, mem_re = 0
- Reset mid-operation abandons the request with no response. A store whose WR edge has not occurred is not written. mem_we must drop combinationally with rst_n so no write occurs at the next edge.
- rsp_valid held with rsp_ready = 0: the unit stalls indefinitely with outputs stable and req_ready = 0.
- mem_we and mem_re are never high in the same cycle.

## Test plan
- Word load: SRAM word 3 = 5; load word addr 0x0C -> rsp_valid 3 cycles after accept, rsp_rdata = 0x00000005, mem_re high exactly 1 cycle.
- Byte-store RMW: SRAM word 5 = 8; store byte 0xAB at 0x15, then word load 0x14 -> rsp_rdata = 0x0000AB08. Store response at cycle 4, mem_re then mem_we one cycle each.
- Signed/unsigned extension: word 2 = 0x80FF7F01.
  - Signed byte at 0x0B -> 0xFFFFFF80.
  - Unsigned half at 0x0A -> 0x000080FF.
  - Signed half at 0x08 -> 0x00007F01.
- Errors:
  - Half at 0x03 -> rsp_err = 1 at cycle 1, no enable asserted.
  - Word at 0x80 (out of range) -> rsp_err = 1.
  - size 11 -> rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles after a load -> rsp_rdata and rsp_valid stable, req_ready = 0. Release -> req_ready = 1 the next cycle.
- Reset mid-RMW: assert rst_n low during CAP of a byte store to word 5 -> outputs reset immediately, no rsp_valid, word 5 still 8 on a later load.
